csel_presum_stage: RTL

CSEL_PRESUM_STAGE -- requirements
Module: csel_presum_stage

---
 rtl/csel_presum_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/csel_presum_stage.sv
// Carry-select presum stage: both high-half candidate sums plus the low-half carry (select),
// held in a 2-entry skid buffer. Optional transfer counter with `define CSEL_STATS_EN.
module csel_presum_stage #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W/2-1:0]   lo_sum,
  output logic             sel,
  output logic [W/2-1:0]   hi_sum0,
  output logic [W/2-1:0]   hi_sum1,
  output logic             hi_cout0,
  output logic             hi_cout1
`ifdef CSEL_STATS_EN
  ,output logic [7:0]      xfer_cnt
`endif
);

  localparam int H = W / 2;

  // Field order matches {carry, sum} of each (H+1)-bit half adder.
  typedef struct packed {
    logic         hi_cout1;
    logic [H-1:0] hi_sum1;
    logic         hi_cout0;
    logic [H-1:0] hi_sum0;
    logic         sel;
    logic [H-1:0] lo_sum;
  } res_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_n;
  res_t   head, skid, nres;
  logic   [H:0] lo_w, hi0_w, hi1_w;
  logic   in_xfer, out_xfer;
  logic   load_head, head_from_skid, load_skid;

  assign lo_w  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign hi0_w = {1'b0, a[W-1:H]} + {1'b0, b[W-1:H]};
  assign hi1_w = hi0_w + {{H{1'b0}}, 1'b1};
  assign nres  = {hi1_w, hi0_w, lo_w};

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_n        = state;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: if (in_xfer) begin
        state_n   = ONE;
        load_head = 1'b1;
      end
      ONE: begin
        if (in_xfer && !out_xfer) begin
          state_n   = TWO;
          load_skid = 1'b1;
        end else if (!in_xfer && out_xfer) begin
          state_n = EMPTY;
        end else if (in_xfer && out_xfer) begin
          load_head = 1'b1;
        end
      end
      TWO: if (out_xfer) begin
        state_n        = ONE;
        load_head      = 1'b1;
        head_from_skid = 1'b1;
      end
      default: state_n = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head      <= '0;
      skid      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n != TWO);
      out_valid <= (state_n != EMPTY);
      if (load_head) head <= head_from_skid ? skid : nres;
      if (load_skid) skid <= nres;
    end
  end

  assign {hi_cout1, hi_sum1, hi_cout0, hi_sum0, sel, lo_sum} = head;

`ifdef CSEL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                             xfer_cnt <= '0;
    else if (out_xfer && xfer_cnt != 8'hFF) xfer_cnt <= xfer_cnt + 8'd1;
  end
`endif

endmodule
